// File: rtl/sys_array_pkg.sv
// rtl/sys_array_pkg.sv - shared types and constant-matrix helpers for the systolic array demonstrator
package sys_array_pkg;

   typedef enum logic [1:0] {IDLE, LOADED, COMPUTE, SHOW} state_t;

   function automatic int acc_width(input int dw);
      return 2 * dw;
   endfunction

   function automatic int a_init(input int i, input int k, input int cols);
      return i * cols + k + 1;
   endfunction

   function automatic int b_init(input int k, input int j);
      return k + j + 1;
   endfunction

endpackage

// File: rtl/systolic_array_wrapper_if.sv
// rtl/systolic_array_wrapper_if.sv - command pulses and display bus of the systolic array demonstrator
interface systolic_array_wrapper_if #(parameter int DATA_WIDTH = 8);

   logic                      load_params;
   logic                      start_comp;
   logic [4*DATA_WIDTH-1:0]   hex_connect;

   modport master (output load_params, output start_comp, input hex_connect);
   modport slave  (input load_params, input start_comp, output hex_connect);

endinterface

// File: rtl/sys_array_cell.sv
// rtl/sys_array_cell.sv - one output-stationary MAC PE with registered operand pass-through
module sys_array_cell #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] a_in,
   input  logic [DATA_WIDTH-1:0] b_in,
   output logic [DATA_WIDTH-1:0] a_out,
   output logic [DATA_WIDTH-1:0] b_out,
   output logic [ACC_WIDTH-1:0]  acc
);

   logic [ACC_WIDTH-1:0] prod;

   assign prod = ACC_WIDTH'(a_in) * ACC_WIDTH'(b_in);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else begin
         a_out <= a_in;
         b_out <= b_in;
         if (en) acc <= acc + prod;
      end
   end

endmodule

// File: rtl/systolic_array_wrapper.sv
// rtl/systolic_array_wrapper.sv - FSM, skewed operand feed, PE grid and divided-rate result display
module systolic_array_wrapper
   import sys_array_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int ARRAY_W      = 4,
   parameter int ARRAY_L      = 4,
   parameter int CLOCK_DIVIDE = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   systolic_array_wrapper_if.slave  bus
);

   localparam int AW  = acc_width(DATA_WIDTH);
   localparam int N   = ARRAY_W + 2 * ARRAY_L - 1;
   localparam int CW  = $clog2(N + 1);
   localparam int RW  = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
   localparam int LW  = (ARRAY_L > 1) ? $clog2(ARRAY_L) : 1;
   localparam int DVW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

   state_t                  state, next_state;
   logic [CW-1:0]           cnt;
   logic [DATA_WIDTH-1:0]   a_reg  [ARRAY_W][ARRAY_L];
   logic [DATA_WIDTH-1:0]   b_reg  [ARRAY_L][ARRAY_L];
   logic [DATA_WIDTH-1:0]   a_feed [ARRAY_W];
   logic [DATA_WIDTH-1:0]   b_feed [ARRAY_L];
   logic [DATA_WIDTH-1:0]   a_bus  [ARRAY_W][ARRAY_L];
   logic [DATA_WIDTH-1:0]   b_bus  [ARRAY_W][ARRAY_L];
   logic [AW-1:0]           acc    [ARRAY_W][ARRAY_L];
   logic [RW-1:0]           row;
   logic [LW-1:0]           col;
   logic [DVW-1:0]          div;
   logic [AW-1:0]           sel_acc;
   logic [4*DATA_WIDTH-1:0] hex;
   logic                    load_ok, start_ok, computing, showing, unused_edge;

   // load_params takes priority over start_comp wherever both are legal
   always_comb begin
      next_state = state;
      load_ok    = 1'b0;
      start_ok   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.load_params) begin
               next_state = LOADED;
               load_ok    = 1'b1;
            end
         end
         LOADED, SHOW: begin
            if (bus.load_params) begin
               next_state = LOADED;
               load_ok    = 1'b1;
            end else if (bus.start_comp) begin
               next_state = COMPUTE;
               start_ok   = 1'b1;
            end
         end
         COMPUTE: begin
            if (cnt == CW'(N - 1)) next_state = SHOW;
         end
         default: next_state = IDLE;
      endcase
   end

   assign computing = (state == COMPUTE);
   assign showing   = (state == SHOW) && (next_state == SHOW);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= next_state;
         cnt   <= computing ? cnt + 1'b1 : '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ARRAY_W; i++)
            for (int k = 0; k < ARRAY_L; k++) a_reg[i][k] <= '0;
         for (int k = 0; k < ARRAY_L; k++)
            for (int j = 0; j < ARRAY_L; j++) b_reg[k][j] <= '0;
      end else if (load_ok) begin
         for (int i = 0; i < ARRAY_W; i++)
            for (int k = 0; k < ARRAY_L; k++) a_reg[i][k] <= DATA_WIDTH'(a_init(i, k, ARRAY_L));
         for (int k = 0; k < ARRAY_L; k++)
            for (int j = 0; j < ARRAY_L; j++) b_reg[k][j] <= DATA_WIDTH'(b_init(k, j));
      end
   end

   // Row i / column j see element k at compute cycle i+k / j+k; zeros elsewhere
   always_comb begin
      for (int i = 0; i < ARRAY_W; i++) begin
         a_feed[i] = '0;
         for (int k = 0; k < ARRAY_L; k++)
            if (computing && cnt == CW'(i + k)) a_feed[i] = a_reg[i][k];
      end
      for (int j = 0; j < ARRAY_L; j++) begin
         b_feed[j] = '0;
         for (int k = 0; k < ARRAY_L; k++)
            if (computing && cnt == CW'(j + k)) b_feed[j] = b_reg[k][j];
      end
   end

   for (genvar i = 0; i < ARRAY_W; i++) begin : g_row
      for (genvar j = 0; j < ARRAY_L; j++) begin : g_col
         logic [DATA_WIDTH-1:0] a_src, b_src;
         if (j == 0) begin : g_a_edge
            assign a_src = a_feed[i];
         end else begin : g_a_link
            assign a_src = a_bus[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign b_src = b_feed[j];
         end else begin : g_b_link
            assign b_src = b_bus[i-1][j];
         end
         sys_array_cell #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(AW)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (computing),
            .clr   (start_ok),
            .a_in  (a_src),
            .b_in  (b_src),
            .a_out (a_bus[i][j]),
            .b_out (b_bus[i][j]),
            .acc   (acc[i][j])
         );
      end
   end

   // Operands leaving the far edges of the grid have no consumer
   always_comb begin
      unused_edge = 1'b0;
      for (int i = 0; i < ARRAY_W; i++) unused_edge = unused_edge ^ (^a_bus[i][ARRAY_L-1]);
      for (int j = 0; j < ARRAY_L; j++) unused_edge = unused_edge ^ (^b_bus[ARRAY_W-1][j]);
   end

   always_comb begin
      sel_acc = '0;
      for (int i = 0; i < ARRAY_W; i++)
         for (int j = 0; j < ARRAY_L; j++)
            if (row == RW'(i) && col == LW'(j)) sel_acc = acc[i][j];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         row <= '0;
         col <= '0;
         div <= '0;
         hex <= '0;
      end else if (!showing) begin
         row <= '0;
         col <= '0;
         div <= '0;
         hex <= '0;
      end else begin
         hex <= {DATA_WIDTH'(row), DATA_WIDTH'(col), sel_acc};
         if (div == DVW'(CLOCK_DIVIDE - 1)) begin
            div <= '0;
            if (col == LW'(ARRAY_L - 1)) begin
               col <= '0;
               row <= (row == RW'(ARRAY_W - 1)) ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

   assign bus.hex_connect = hex;

endmodule

// File: tb/tb_systolic_array_wrapper.sv
// tb/tb_systolic_array_wrapper.sv - self-checking bench for the default and a small 2x3 systolic wrapper
module tb_systolic_array_wrapper;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   systolic_array_wrapper_if #(.DATA_WIDTH(8)) bus0 ();
   systolic_array_wrapper_if #(.DATA_WIDTH(8)) bus1 ();

   systolic_array_wrapper #(.DATA_WIDTH(8), .ARRAY_W(4), .ARRAY_L(4), .CLOCK_DIVIDE(2)) dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   systolic_array_wrapper #(.DATA_WIDTH(8), .ARRAY_W(2), .ARRAY_L(3), .CLOCK_DIVIDE(1)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   logic [31:0] hex0, hex1;
   assign hex0 = bus0.hex_connect;
   assign hex1 = bus1.hex_connect;

   typedef struct {
      int          sel;
      int          idx;
      logic [31:0] exp;
   } vec_t;

   vec_t        vecs [10];
   logic [31:0] exp_q [$];
   logic [31:0] cap [32];

   function automatic logic [31:0] model_word(input int i, input int j, input int l);
      logic [15:0] c;
      c = '0;
      for (int k = 0; k < l; k++) c = c + 16'(((i * l + k + 1) & 255) * ((k + j + 1) & 255));
      return {8'(i), 8'(j), c};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] cur_hex(input int sel);
      return (sel == 1) ? hex1 : hex0;
   endfunction

   // sel 0/1 picks one instance, 2 drives both
   task automatic pulse(input int sel, input logic ld, input logic st);
      @(negedge clk);
      if (sel != 1) begin bus0.load_params = ld; bus0.start_comp = st; end
      if (sel != 0) begin bus1.load_params = ld; bus1.start_comp = st; end
      @(negedge clk);
      bus0.load_params = 1'b0; bus0.start_comp = 1'b0;
      bus1.load_params = 1'b0; bus1.start_comp = 1'b0;
   endtask

   task automatic run_show(input int sel, input int w, input int l, input int cd, input int nwords);
      int n_cyc;
      logic [31:0] cur;
      n_cyc = w + 2 * l - 1;
      for (int n = 0; n < nwords; n++)
         exp_q.push_back(model_word((n % (w * l)) / l, (n % (w * l)) % l, l));
      pulse(sel, 1'b0, 1'b1);
      for (int m = 0; m <= n_cyc; m++) begin
         if (m > 0) @(negedge clk);
         chk($sformatf("compute_zero_%0d_%0d", sel, m), cur_hex(sel), 32'h0);
      end
      for (int n = 0; n < nwords; n++) begin
         for (int c = 0; c < cd; c++) begin
            @(negedge clk);
            cur = cur_hex(sel);
            chk($sformatf("show_word_%0d_%0d_%0d", sel, n, c), cur, exp_q[0]);
            if (c == 0) cap[n] = cur;
         end
         void'(exp_q.pop_front());
      end
   endtask

   task automatic check_table(input int sel);
      foreach (vecs[v])
         if (vecs[v].sel == sel)
            chk($sformatf("table_%0d_%0d", sel, vecs[v].idx), cap[vecs[v].idx], vecs[v].exp);
   endtask

   initial begin
      vecs[0] = '{0, 0,  32'h0000_001E};
      vecs[1] = '{0, 1,  32'h0001_0028};
      vecs[2] = '{0, 2,  32'h0002_0032};
      vecs[3] = '{0, 4,  32'h0100_0046};
      vecs[4] = '{0, 15, 32'h0303_0144};
      vecs[5] = '{0, 16, 32'h0000_001E};
      vecs[6] = '{1, 0,  32'h0000_000E};
      vecs[7] = '{1, 1,  32'h0001_0014};
      vecs[8] = '{1, 5,  32'h0102_003E};
      vecs[9] = '{1, 6,  32'h0000_000E};

      bus0.load_params = 1'b0; bus0.start_comp = 1'b0;
      bus1.load_params = 1'b0; bus1.start_comp = 1'b0;

      #1;
      chk("reset_hex0", hex0, 32'h0);
      chk("reset_hex1", hex1, 32'h0);
      #79 reset = 1'b0;
      #1;
      chk("post_reset_hex0", hex0, 32'h0);
      chk("post_reset_hex1", hex1, 32'h0);

      pulse(2, 1'b0, 1'b1);
      repeat (16) begin
         @(negedge clk);
         chk("idle_start_hex0", hex0, 32'h0);
         chk("idle_start_hex1", hex1, 32'h0);
      end

      pulse(2, 1'b1, 1'b0);
      repeat (3) begin
         @(negedge clk);
         chk("loaded_hex0", hex0, 32'h0);
         chk("loaded_hex1", hex1, 32'h0);
      end

      run_show(0, 4, 4, 2, 17);
      check_table(0);
      run_show(0, 4, 4, 2, 17);
      check_table(0);
      run_show(1, 2, 3, 1, 7);
      check_table(1);

      pulse(0, 1'b1, 1'b1);
      repeat (15) begin
         @(negedge clk);
         chk("load_wins_hex0", hex0, 32'h0);
      end

      pulse(0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("reset_compute_hex0", hex0, 32'h0);
      chk("reset_show_hex1", hex1, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      pulse(2, 1'b0, 1'b1);
      repeat (20) begin
         @(negedge clk);
         chk("no_reload_hex0", hex0, 32'h0);
         chk("no_reload_hex1", hex1, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
